// File: rtl/fp_norm_round_pkg.sv
// Shared definitions for the FP normalise/round stage: default widths,
// FSM state codes, flag bit positions and a flag-packing helper.
package fp_norm_round_pkg;

    localparam int DEF_EXP_W  = 8;
    localparam int DEF_FRAC_W = 23;

    // FSM state codes (2-bit, legacy-compatible encoding)
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_ROUND = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Bit positions inside out_flags = {overflow, underflow, inexact, zero}
    localparam int FLAG_OVF  = 3;
    localparam int FLAG_UNF  = 2;
    localparam int FLAG_INX  = 1;
    localparam int FLAG_ZERO = 0;

    function automatic logic [3:0] pack_flags(input logic ovf, input logic unf,
                                              input logic inx, input logic zero);
        logic [3:0] f;
        f            = '0;
        f[FLAG_OVF]  = ovf;
        f[FLAG_UNF]  = unf;
        f[FLAG_INX]  = inx;
        f[FLAG_ZERO] = zero;
        return f;
    endfunction

endpackage

// File: rtl/fp_norm_round_rne.sv
// Combinational round-to-nearest-even on a {frac, G, R, S} vector.
// A carry out of the fraction is reported as mant_ovf; the fraction then wraps to zero.
module fp_round_rne #(
    parameter int FRAC_W = 23
) (
    input  logic [FRAC_W+2:0] frac_grs,
    output logic [FRAC_W-1:0] frac_rounded,
    output logic              mant_ovf,
    output logic              inexact
);
    logic              g;
    logic              r;
    logic              s;
    logic              inc;
    logic [FRAC_W:0]   sum_ext;

    // Round-half-to-even increment and fraction add with carry out
    always_comb begin
        g            = frac_grs[2];
        r            = frac_grs[1];
        s            = frac_grs[0];
        inc          = g & (r | s | frac_grs[3]);
        sum_ext      = {1'b0, frac_grs[FRAC_W+2:3]} + {{FRAC_W{1'b0}}, inc};
        frac_rounded = sum_ext[FRAC_W-1:0];
        mant_ovf     = sum_ext[FRAC_W];
        inexact      = g | r | s;
    end

endmodule

// File: rtl/fp_norm_round.sv
// FP adder back end: iterative one-bit-per-cycle normalisation, RNE rounding,
// IEEE-754 packing and a valid/ready output register. Denormals flush to signed zero.
module fp_norm_round
    import fp_norm_round_pkg::*;
#(
    parameter int EXP_W  = DEF_EXP_W,
    parameter int FRAC_W = DEF_FRAC_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sign,
    input  logic [EXP_W-1:0]        in_exp,
    input  logic [FRAC_W+4:0]       in_sum,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+FRAC_W:0]   out_result,
    output logic [3:0]              out_flags
);
    localparam int SUM_W = FRAC_W + 5;
    localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};
    localparam logic [EXP_W:0] EXP_ONE = {{EXP_W{1'b0}}, 1'b1};

    logic [1:0]        state;
    logic              w_sign;
    logic [EXP_W:0]    w_exp;
    logic [SUM_W-1:0]  w_sum;

    logic [FRAC_W-1:0] frac_rnd;
    logic              mant_ovf;
    logic              rnd_inexact;
    logic [EXP_W:0]    exp_rnd;

    fp_round_rne #(
        .FRAC_W (FRAC_W)
    ) u_round (
        .frac_grs     (w_sum[FRAC_W+2:0]),
        .frac_rounded (frac_rnd),
        .mant_ovf     (mant_ovf),
        .inexact      (rnd_inexact)
    );

    // Handshake outputs and post-round exponent
    always_comb begin
        in_ready  = (state == ST_IDLE) && rst_n;
        out_valid = (state == ST_DONE);
        exp_rnd   = w_exp + {{EXP_W{1'b0}}, mant_ovf};
    end

    // FSM, work registers and output register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            w_sign     <= 1'b0;
            w_exp      <= '0;
            w_sum      <= '0;
            out_result <= '0;
            out_flags  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        w_sign <= in_sign;
                        w_exp  <= {1'b0, in_exp};
                        w_sum  <= in_sum;
                        state  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (w_sum == '0) begin
                        out_result <= '0;
                        out_flags  <= pack_flags(1'b0, 1'b0, 1'b0, 1'b1);
                        state      <= ST_DONE;
                    end else if (w_sum[SUM_W-1]) begin
                        // right shift keeps the lost bit alive in sticky
                        w_sum <= {1'b0, w_sum[SUM_W-1:2], w_sum[1] | w_sum[0]};
                        w_exp <= w_exp + EXP_ONE;
                        state <= ST_ROUND;
                    end else if (w_sum[SUM_W-2]) begin
                        state <= ST_ROUND;
                    end else if (w_exp <= EXP_ONE) begin
                        out_result <= {w_sign, {(EXP_W+FRAC_W){1'b0}}};
                        out_flags  <= pack_flags(1'b0, 1'b1, 1'b1, 1'b1);
                        state      <= ST_DONE;
                    end else begin
                        w_sum <= {w_sum[SUM_W-2:0], 1'b0};
                        w_exp <= w_exp - EXP_ONE;
                    end
                end
                ST_ROUND: begin
                    if (exp_rnd >= EXP_MAX) begin
                        out_result <= {w_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                        out_flags  <= pack_flags(1'b1, 1'b0, 1'b1, 1'b0);
                    end else begin
                        out_result <= {w_sign, exp_rnd[EXP_W-1:0], frac_rnd};
                        out_flags  <= pack_flags(1'b0, 1'b0, rnd_inexact, 1'b0);
                    end
                    state <= ST_DONE;
                end
                default: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_norm_round.sv
// Directed bench for fp_norm_round: hand-computed results, flags and latencies,
// plus backpressure and mid-operation reset.
module tb_fp_norm_round;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [27:0] in_sum;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_flags;

    int n_checks = 0;
    int n_fail   = 0;

    fp_norm_round #(
        .EXP_W  (8),
        .FRAC_W (23)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_sum     (in_sum),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Issue one operation from IDLE (called at a negedge), wait for the result,
    // check it, optionally hold out_ready low for 'hold' cycles, then drain.
    task automatic do_op(input string tag, input logic s, input logic [7:0] e,
                         input logic [27:0] sm, input logic [31:0] er,
                         input logic [3:0] ef, input int el, input int hold);
        int lat;
        chk({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
        in_sign  = s;
        in_exp   = e;
        in_sum   = sm;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, ".valid"},   {31'd0, out_valid}, 32'd1);
        chk({tag, ".result"},  out_result, er);
        chk({tag, ".flags"},   {28'd0, out_flags}, {28'd0, ef});
        chk({tag, ".latency"}, lat, el);
        for (int i = 0; i < hold; i++) begin
            // unrelated input offered while stalled must not be taken
            in_valid = 1'b1;
            in_sum   = '0;
            @(negedge clk);
            chk({tag, ".hold_result"},   out_result, er);
            chk({tag, ".hold_valid"},    {31'd0, out_valid}, 32'd1);
            chk({tag, ".hold_in_ready"}, {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, ".drop_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, ".idle_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = '0;
        in_sum    = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.out_valid",  {31'd0, out_valid}, 32'd0);
        chk("rst.out_result", out_result, 32'd0);
        chk("rst.out_flags",  {28'd0, out_flags}, 32'd0);
        chk("rst.in_ready",   {31'd0, in_ready}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op("carry",    1'b0, 8'h81, {2'b10, 23'h0, 3'b000},       32'h41000000, 4'b0000, 3, 0);
        do_op("cancel",   1'b0, 8'h7F, {3'b001, 22'h0, 3'b000},      32'h3F000000, 4'b0000, 4, 0);
        do_op("tie_odd",  1'b0, 8'h7F, {2'b01, 23'h000001, 3'b100},  32'h3F800002, 4'b0010, 3, 0);
        do_op("tie_even", 1'b0, 8'h7F, {2'b01, 23'h0, 3'b100},       32'h3F800000, 4'b0010, 3, 0);
        do_op("rnd_up",   1'b1, 8'h7F, {2'b01, 23'h0, 3'b101},       32'hBF800001, 4'b0010, 3, 0);
        do_op("mant_ovf", 1'b0, 8'h7F, {2'b01, 23'h7FFFFF, 3'b110},  32'h40000000, 4'b0010, 3, 0);
        do_op("sticky",   1'b0, 8'h80, {2'b11, 23'h0, 3'b011},       32'h40C00000, 4'b0010, 3, 0);
        do_op("overflow", 1'b0, 8'hFE, {2'b11, 23'h7FFFFF, 3'b000},  32'h7F800000, 4'b1010, 3, 0);
        do_op("zero",     1'b1, 8'h90, 28'h0,                         32'h00000000, 4'b0001, 2, 0);
        do_op("flush",    1'b0, 8'h01, {3'b001, 22'h0, 3'b000},      32'h00000000, 4'b0111, 2, 0);
        do_op("flush_neg",1'b1, 8'h02, {4'b0001, 21'h0, 3'b000},     32'h80000000, 4'b0111, 3, 0);
        do_op("long",     1'b0, 8'h7F, 28'h0000008,                  32'h34000000, 4'b0000, 26, 0);
        do_op("backpr",   1'b0, 8'h81, {2'b10, 23'h0, 3'b000},       32'h41000000, 4'b0000, 3, 5);

        // reset while normalising: operation is discarded
        in_sign  = 1'b0;
        in_exp   = 8'h7F;
        in_sum   = 28'h0000001;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid.out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_mid.in_ready",  {31'd0, in_ready}, 32'd0);
        chk("rst_mid.out_result", out_result, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_mid.in_ready_release", {31'd0, in_ready}, 32'd1);
        repeat (30) @(negedge clk);
        chk("rst_mid.no_output", {31'd0, out_valid}, 32'd0);
        do_op("after_rst", 1'b1, 8'h81, {2'b10, 23'h0, 3'b000}, 32'hC1000000, 4'b0000, 3, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
